aes_inv_key_sched: RTL and testbench
====================================

Name: aes_inv_key_sched

Overview:
- On-the-fly reverse AES-128 key scheduler for the decryption datapath.
- Emits round keys in decryption order, 10 down to 0, one per consumer handshake. Only the current 128-bit key is held; no 11-entry key ROM.
- Accepts either the cipher key, which is expanded forward internally to round 10, or an already-known round-10 key.
- Sits between the key input and the round engine, which pulls keys with a valid/advance handshake.

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128. Other values are unsupported.

Ports:
- CLK  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a schedule. Sampled only in IDLE.
- key_is_last  in  1  sampled with start. 1 = key_in is the round-10 key; 0 = key_in is the cipher key.
- key_in  in  128  key, FIPS-197 byte order; bits [127:96] = w0.
- key_out  out  128  current round key.
- key_idx  out  4  round number of key_out, 10..0.
- key_valid  out  1  key_out/key_idx are valid.
- key_advance  in  1  consumer accepts key_out. Meaningful only when key_valid=1.
- busy  out  1  high in FWD and REV.
- done  out  1  one-cycle pulse after round key 0 is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, key_out=0, key_idx=0, key_valid=0, busy=0, done=0. The forward counter and Rcon index clear. Reset mid-schedule aborts immediately; no partial output.
- States:
  - IDLE: start=1 captures key_in into the key register. If key_is_last=1, go to REV with key_idx=10. If key_is_last=0, go to FWD with fwd_cnt=1.
  - FWD: each cycle, key <= fwd_step(key, Rcon[fwd_cnt]), then fwd_cnt++. After the step with fwd_cnt=10, go to REV with key_idx=10. Latency from start to key_valid is 11 cycles.
  - REV: key_valid=1.
    - key_advance=1 and key_idx>0: key <= inv_step(key, Rcon[key_idx]), key_idx--. The next key is valid the next cycle, so there is 1 cycle per key with no bubble.
    - key_advance=1 and key_idx=0: key_valid<=0, done<=1 for one cycle, go to IDLE. key_out holds the round-0 key.
    - key_advance=0: key_out and key_idx hold indefinitely.
  - Latency from start to key_valid when key_is_last=1: 1 cycle.
- Forward step (word index w0..w3): t=SubWord(RotWord(w3))^{Rcon,24'h0}; n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2.
- Inverse step: p3=w3^w2; p2=w2^w1; p1=w1^w0; p0=w0^SubWord(RotWord(p3))^{Rcon,24'h0}.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- The forward and inverse steps share one 4-lookup S-box instance. A mux selects w3 (FWD) or w3^w2 (REV).
- start while busy=1: ignored. No restart and no error flag.
- key_advance while key_valid=0: ignored.
- start and done in the same cycle: done is only asserted on entry to IDLE, so start is honoured on the next cycle.
- key_is_last and key_in are sampled only on the start cycle. Later changes have no effect.

Decomposition:
- Package aes_pkg: the 256-entry forward S-box function, the Rcon table function indexed 1..10, state encoding (IDLE, FWD, REV), and word-slice constants.
- Sub-module aes_subword: 32-bit SubWord, four S-box lookups, purely combinational. It is instantiated once and shareable with the forward KeyGeneration.

Test Plan:
1. Cipher key 2b7e151628aed2a6abf7158809cf4f3c, key_is_last=0, key_advance held 1:
   - key_valid rises 11 cycles after start.
   - key_idx=10, key_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Next cycle: key_idx=9, key_out=ac7766f319fadc2128d12941575c006e.
   - key_idx=1: key_out=a0fafe1788542cb123a339392a6c7605.
   - key_idx=0: key_out=2b7e…4f3c; done pulses one cycle later.
2. key_is_last=1, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6:
   - key_valid is high 1 cycle after start.
   - The same sequence 10..0 as scenario 1 follows.
3. Backpressure: in scenario 2, hold key_advance=0 for 5 cycles at key_idx=7:
   - key_out and key_idx stay constant.
   - Release: the sequence resumes with key_idx=6 and no key is skipped.
4. start pulsed during FWD and during REV:
   - The sequence is unaffected.
   - busy stays 1 until done.
5. rst_n low during REV at key_idx=4:
   - All outputs go to 0 asynchronously.
   - After release, a new start with the scenario 2 key restarts cleanly at key_idx=10.
6. Random 128-bit keys (≥100), key_is_last=0, key_advance randomized:
   - Each accepted key matches a reference forward expansion, in reverse order.
   - Exactly 11 handshakes and one done pulse per start.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: S-box, Rcon, FSM encoding, word slices.
package aes_pkg;

   localparam int unsigned KEY_W  = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned IDX_W  = 4;

   // MSB positions of w0..w3 within a 128-bit key (w0 is the leftmost word)
   localparam int unsigned W0_HI = 127;
   localparam int unsigned W1_HI = 95;
   localparam int unsigned W2_HI = 63;
   localparam int unsigned W3_HI = 31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      REV  = 2'd2
   } state_t;

   // Forward S-box; entry 0 is the leftmost byte
   localparam logic [0:255][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[b];
   endfunction

   // Round constant for rounds 1..10; other indices return zero
   function automatic logic [7:0] rcon(input logic [IDX_W-1:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
   import aes_pkg::*;
(
   input  logic [WORD_W-1:0] dataIn,
   output logic [WORD_W-1:0] dataOut_c
);

   // One lookup per byte lane
   for (genvar i = 0; i < 4; i++) begin : gLookup
      assign dataOut_c[BYTE_W*i +: BYTE_W] = sbox(dataIn[BYTE_W*i +: BYTE_W]);
   end

endmodule

// File: rtl/aes_inv_key_sched.sv
// On-the-fly reverse AES-128 key scheduler: emits round keys 10..0 on a
// valid/advance handshake, holding only the current key.
module aes_inv_key_sched
   import aes_pkg::*;
#(
   parameter int unsigned NR = 10   // only 10 (AES-128) is supported
)(
   input  logic               CLK,
   input  logic               rst_n,
   input  logic               start,
   input  logic               key_is_last,
   input  logic [KEY_W-1:0]   key_in,
   output logic [KEY_W-1:0]   key_out,
   output logic [IDX_W-1:0]   key_idx,
   output logic               key_valid,
   input  logic               key_advance,
   output logic               busy,
   output logic               done
);

   state_t             state;
   logic [IDX_W-1:0]   fwdCnt;

   logic [WORD_W-1:0]  w0, w1, w2, w3;
   logic [WORD_W-1:0]  subSel, subRot, subOut, tWord;
   logic [IDX_W-1:0]   rconIdx;
   logic [WORD_W-1:0]  n0, n1, n2, n3;
   logic [KEY_W-1:0]   fwdKey, invKey;

   assign w0 = key_out[W0_HI -: WORD_W];
   assign w1 = key_out[W1_HI -: WORD_W];
   assign w2 = key_out[W2_HI -: WORD_W];
   assign w3 = key_out[W3_HI -: WORD_W];

   // Shared S-box input: w3 going forward, recovered previous w3 (w3^w2) going back
   assign subSel  = (state == REV) ? (w3 ^ w2) : w3;
   assign subRot  = {subSel[23:0], subSel[31:24]};
   assign rconIdx = (state == REV) ? key_idx : fwdCnt;

   aes_subword uSubWord (
      .dataIn    (subRot),
      .dataOut_c (subOut)
   );

   assign tWord = subOut ^ {rcon(rconIdx), 24'h000000};

   // Forward step: round r-1 -> r
   assign n0     = w0 ^ tWord;
   assign n1     = w1 ^ n0;
   assign n2     = w2 ^ n1;
   assign n3     = w3 ^ n2;
   assign fwdKey = {n0, n1, n2, n3};

   // Inverse step: round r -> r-1
   assign invKey = {w0 ^ tWord, w1 ^ w0, w2 ^ w1, w3 ^ w2};

   // Schedule FSM with registered key, index and handshake outputs
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fwdCnt    <= '0;
         key_out   <= '0;
         key_idx   <= '0;
         key_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  key_out <= key_in;
                  busy    <= 1'b1;
                  if (key_is_last) begin
                     state     <= REV;
                     key_idx   <= IDX_W'(NR);
                     key_valid <= 1'b1;
                  end else begin
                     state  <= FWD;
                     fwdCnt <= IDX_W'(1);
                  end
               end
            end
            FWD: begin
               key_out <= fwdKey;
               fwdCnt  <= fwdCnt + IDX_W'(1);
               if (fwdCnt == IDX_W'(NR)) begin
                  state     <= REV;
                  fwdCnt    <= '0;
                  key_idx   <= IDX_W'(NR);
                  key_valid <= 1'b1;
               end
            end
            REV: begin
               if (key_advance) begin
                  if (key_idx != '0) begin
                     key_out <= invKey;
                     key_idx <= key_idx - IDX_W'(1);
                  end else begin
                     state     <= IDLE;
                     key_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched against a FIPS-197 key expansion model.
module tb_aes_inv_key_sched;

   logic         CLK = 1'b0;
   logic         rst_n;
   logic         start;
   logic         key_is_last;
   logic [127:0] key_in;
   logic [127:0] key_out;
   logic [3:0]   key_idx;
   logic         key_valid;
   logic         key_advance;
   logic         busy;
   logic         done;

   int passCnt  = 0;
   int totalCnt = 0;

   logic [7:0]   sboxM [0:255];
   logic [7:0]   rconM [1:10];
   logic [127:0] expRk [0:10];
   logic [127:0] obsKey [0:10];
   int           obsLat;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;

   always #5 CLK = ~CLK;

   aes_inv_key_sched dut (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .start       (start),
      .key_is_last (key_is_last),
      .key_in      (key_in),
      .key_out     (key_out),
      .key_idx     (key_idx),
      .key_valid   (key_valid),
      .key_advance (key_advance),
      .busy        (busy),
      .done        (done)
   );

   // GF(2^8) arithmetic used to derive the S-box from first principles
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      return d[15-n -: 8];
   endfunction

   task automatic build_tables();
      logic [7:0] inv, r;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0)
            for (int y = 1; y < 256; y++)
               if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sboxM[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      r = 8'h01;
      for (int i = 1; i <= 10; i++) begin
         rconM[i] = r;
         r = xtime(r);
      end
   endtask

   // Textbook 44-word expansion; round key r = w[4r..4r+3]
   task automatic model_expand(input logic [127:0] ck);
      logic [31:0] w [0:43];
      logic [31:0] temp;
      for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         temp = w[i-1];
         if (i % 4 == 0)
            temp = {sboxM[temp[23:16]], sboxM[temp[15:8]], sboxM[temp[7:0]], sboxM[temp[31:24]]}
                   ^ {rconM[i/4], 24'h000000};
         w[i] = w[i-4] ^ temp;
      end
      for (int r = 0; r <= 10; r++)
         expRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Runs one full schedule, checking every cycle against the model
   task automatic run_schedule(input logic [127:0] ck, input bit isLast, input int advPct,
                               input int holdIdx, input bit pokeStart, input string tag);
      int  expIdx, lat, holdLeft, budget;
      bit  adv;
      model_expand(ck);
      @(negedge CLK);
      start       = 1'b1;
      key_is_last = isLast;
      key_in      = isLast ? expRk[10] : ck;
      key_advance = 1'($urandom % 2);
      @(negedge CLK);
      start       = 1'b0;
      key_in      = rand128();
      key_is_last = 1'($urandom % 2);
      lat = 1;
      while (key_valid !== 1'b1 && lat < 40) begin
         totalCnt++;
         if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL %s busy_fwd: busy=%b done=%b want busy=1 done=0", tag, busy, done);
         else passCnt++;
         if (pokeStart) start = ($urandom % 3 == 0);
         key_in      = rand128();
         key_is_last = 1'($urandom % 2);
         key_advance = 1'($urandom % 2);
         @(negedge CLK);
         lat++;
      end
      obsLat = lat;
      totalCnt++;
      if (lat != (isLast ? 1 : 11))
         $display("FAIL %s latency: got %0d cycles want %0d", tag, lat, isLast ? 1 : 11);
      else passCnt++;
      if (key_valid !== 1'b1) begin
         start = 1'b0;
         return;
      end

      expIdx = 10; holdLeft = -1; budget = 0;
      while (expIdx >= 0 && budget < 400) begin
         totalCnt++;
         if (key_idx !== 4'(expIdx))
            $display("FAIL %s key_idx: got %0d want %0d", tag, key_idx, expIdx);
         else passCnt++;
         totalCnt++;
         if (key_out !== expRk[expIdx])
            $display("FAIL %s key_out[%0d]: got %h want %h", tag, expIdx, key_out, expRk[expIdx]);
         else passCnt++;
         totalCnt++;
         if ({key_valid, busy, done} !== 3'b110)
            $display("FAIL %s flags_rev: valid/busy/done=%b want 110", tag, {key_valid, busy, done});
         else passCnt++;
         obsKey[expIdx] = key_out;
         if (expIdx == holdIdx && holdLeft < 0) holdLeft = 5;
         if (holdLeft > 0) begin
            adv = 1'b0;
            holdLeft--;
         end else begin
            adv = ($urandom_range(99) < advPct);
         end
         key_advance = adv;
         if (pokeStart) start = ($urandom % 3 == 0);
         key_in      = rand128();
         key_is_last = 1'($urandom % 2);
         @(negedge CLK);
         budget++;
         if (adv) expIdx--;
      end
      start       = 1'b0;
      key_advance = 1'b0;
      totalCnt++;
      if (expIdx >= 0)
         $display("FAIL %s handshake_timeout: reached idx %0d want -1", tag, expIdx);
      else passCnt++;
      totalCnt++;
      if ({key_valid, busy, done} !== 3'b001)
         $display("FAIL %s flags_done: valid/busy/done=%b want 001", tag, {key_valid, busy, done});
      else passCnt++;
      totalCnt++;
      if (key_out !== expRk[0])
         $display("FAIL %s hold_round0: got %h want %h", tag, key_out, expRk[0]);
      else passCnt++;
      @(negedge CLK);
      totalCnt++;
      if (done !== 1'b0)
         $display("FAIL %s done_pulse: done=%b want 0", tag, done);
      else passCnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; key_is_last = 1'b0; key_in = rand128(); key_advance = 1'b0;
      #1;
      totalCnt++;
      if ({key_out, key_idx, key_valid, busy, done} !== '0)
         $display("FAIL reset_state: key_out=%h idx=%0d v/b/d=%b want all 0",
                  key_out, key_idx, {key_valid, busy, done});
      else passCnt++;
      repeat (2) @(negedge CLK);
      rst_n = 1'b1;
   endtask

   task automatic test_fips_fwd();
      run_schedule(FIPS_KEY, 1'b0, 100, -1, 1'b0, "fips_fwd");
      totalCnt++;
      if (obsKey[10] !== FIPS_R10) $display("FAIL fips_fwd_r10: got %h want %h", obsKey[10], FIPS_R10);
      else passCnt++;
      totalCnt++;
      if (obsKey[9] !== FIPS_R9) $display("FAIL fips_fwd_r9: got %h want %h", obsKey[9], FIPS_R9);
      else passCnt++;
      totalCnt++;
      if (obsKey[1] !== FIPS_R1) $display("FAIL fips_fwd_r1: got %h want %h", obsKey[1], FIPS_R1);
      else passCnt++;
      totalCnt++;
      if (obsKey[0] !== FIPS_KEY) $display("FAIL fips_fwd_r0: got %h want %h", obsKey[0], FIPS_KEY);
      else passCnt++;
   endtask

   task automatic test_fips_last();
      run_schedule(FIPS_KEY, 1'b1, 100, -1, 1'b0, "fips_last");
      totalCnt++;
      if (obsKey[9] !== FIPS_R9) $display("FAIL fips_last_r9: got %h want %h", obsKey[9], FIPS_R9);
      else passCnt++;
      totalCnt++;
      if (obsKey[0] !== FIPS_KEY) $display("FAIL fips_last_r0: got %h want %h", obsKey[0], FIPS_KEY);
      else passCnt++;
   endtask

   task automatic test_backpressure();
      run_schedule(FIPS_KEY, 1'b1, 100, 7, 1'b0, "backpressure");
   endtask

   task automatic test_start_ignored();
      run_schedule(FIPS_KEY, 1'b0, 70, -1, 1'b1, "start_in_fwd");
      run_schedule(rand128(), 1'b1, 70, -1, 1'b1, "start_in_rev");
   endtask

   task automatic test_reset_mid();
      int n = 0;
      model_expand(FIPS_KEY);
      @(negedge CLK);
      start = 1'b1; key_is_last = 1'b1; key_in = expRk[10]; key_advance = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      while (key_idx !== 4'd4 && n < 40) begin
         @(negedge CLK);
         n++;
      end
      key_advance = 1'b0;
      totalCnt++;
      if (key_idx !== 4'd4) $display("FAIL reset_mid_reach: idx=%0d want 4", key_idx);
      else passCnt++;
      #2 rst_n = 1'b0;
      #1;
      totalCnt++;
      if ({key_out, key_idx, key_valid, busy, done} !== '0)
         $display("FAIL reset_mid_async: key_out=%h idx=%0d v/b/d=%b want all 0",
                  key_out, key_idx, {key_valid, busy, done});
      else passCnt++;
      @(negedge CLK);
      rst_n = 1'b1;
      run_schedule(FIPS_KEY, 1'b1, 100, -1, 1'b0, "post_reset");
      totalCnt++;
      if (obsKey[10] !== FIPS_R10) $display("FAIL post_reset_r10: got %h want %h", obsKey[10], FIPS_R10);
      else passCnt++;
   endtask

   task automatic test_random();
      for (int k = 0; k < 100; k++)
         run_schedule(rand128(), 1'b0, 60, -1, 1'b0, "random_fwd");
      for (int k = 0; k < 10; k++)
         run_schedule(rand128(), 1'b1, 50, -1, 1'b0, "random_last");
   endtask

   initial begin
      build_tables();
      test_reset();
      test_fips_fwd();
      test_fips_last();
      test_backpressure();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
